// File: rtl/cpu16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu16_pkg
// Description : Shared types and constants for the cpu16 front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu16_pkg;

    localparam int          c_instr_w = 16;
    localparam logic [15:0] c_pc_inc  = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    function automatic logic [15:0] next_pc(input logic [15:0] pc);
        return pc + c_pc_inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Power-of-two FIFO holding fetched {instr, pc} entries.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !flush)
            r_mem[r_wr_ptr] <= wdata;
    end

    // Flush wins over push and pop so a redirect leaves the queue empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch with one outstanding request and a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu16_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    localparam int                   c_cnt_w    = $clog2(DEPTH) + 1;
    localparam int                   c_entry_w  = 2 * c_instr_w;
    localparam logic [c_cnt_w-1:0]   c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]   c_depth_m1 = c_cnt_w'(DEPTH - 1);

    fetch_state_t         r_state;
    logic [15:0]          r_fetch_pc;
    logic [15:0]          r_req_addr;
    logic                 r_req;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic [c_entry_w-1:0] w_head;
    logic [c_cnt_w-1:0]   w_count;
    logic [15:0]          w_redirect_pc;
    logic [15:0]          w_next_addr;

    assign w_redirect_pc = {redirect_pc[15:1], 1'b0};
    assign w_next_addr   = next_pc(r_req_addr);
    assign w_pop         = ~w_empty & instr_ready;
    assign w_push        = (r_state == ST_WAIT) & imem_ack & ~redirect_valid;

    assign imem_req    = r_req;
    assign imem_addr   = r_req_addr;
    assign instr_valid = ~w_empty;
    assign instr       = w_empty ? 16'h0000 : w_head[c_entry_w-1:c_instr_w];
    assign instr_pc    = w_empty ? 16'h0000 : w_head[c_instr_w-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata ({imem_rdata, r_req_addr}),
        .pop   (w_pop),
        .flush (redirect_valid),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_req      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                    end else if (w_count < c_depth) begin
                        r_state    <= ST_WAIT;
                        r_req      <= 1'b1;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                        if (imem_ack) begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else if (imem_ack) begin
                        r_fetch_pc <= w_next_addr;
                        // A same-cycle pop keeps the count, so room remains.
                        if (w_pop || (w_count < c_depth_m1)) begin
                            r_req_addr <= w_next_addr;
                        end else begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (redirect_valid)
                        r_fetch_pc <= w_redirect_pc;
                    if (imem_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import cpu16_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    // Memory model: zero-wait echo of the address, or manual response.
    logic        zw = 1'b0;
    logic        man_ack = 1'b0;
    logic [15:0] man_rdata = 16'h0000;

    int checks = 0;
    int errors = 0;

    assign imem_ack   = zw ? imem_req : man_ack;
    assign imem_rdata = zw ? imem_addr : man_rdata;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    task automatic do_reset;
        rst            = 1'b1;
        zw             = 1'b0;
        man_ack        = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h want 0000", instr); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", instr_pc); end
        checks++; if (dut.w_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", dut.w_count); end
    endtask

    task automatic test_stream;
        do_reset();
        zw = 1'b1; instr_ready = 1'b1; rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL stream_first_req got %0b/%h want 1/0000", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %0b want 0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(2 * i) || instr !== 16'(2 * i)) begin
                errors++;
                $display("FAIL stream_%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", i, instr_valid, instr_pc, instr, 16'(2 * i), 16'(2 * i));
            end
        end
    endtask

    task automatic test_full;
        int acks;
        do_reset();
        zw = 1'b1; instr_ready = 1'b0; rst = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req && imem_ack) acks++;
        end
        checks++; if (acks != 4) begin errors++; $display("FAIL full_acks got %0d want 4", acks); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %0b want 0", imem_req); end
        checks++; if (dut.w_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", dut.w_count); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL full_head got %h want 0000", instr_pc); end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req && imem_ack) acks++;
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL refill_acks got %0d want 1", acks); end
        checks++; if (dut.w_count !== 3'd4) begin errors++; $display("FAIL refill_count got %0d want 4", dut.w_count); end
        checks++; if (instr_pc !== 16'h0002) begin errors++; $display("FAIL refill_head got %h want 0002", instr_pc); end
    endtask

    task automatic test_redirect_discard;
        do_reset();
        zw = 1'b0; instr_ready = 1'b1; rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL disc_req got %0b/%h want 1/0000", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 16'h0041;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (dut.r_state !== ST_DISCARD) begin errors++; $display("FAIL disc_state got %0d want %0d", dut.r_state, ST_DISCARD); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL disc_hold got %0b/%h want 1/0000", imem_req, imem_addr); end
        @(negedge clk);
        man_ack = 1'b1; man_rdata = 16'hDEAD;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL disc_drop got req=%0b v=%0b want 0/0", imem_req, instr_valid); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL disc_newreq got %0b/%h want 1/0040", imem_req, imem_addr); end
        man_ack = 1'b1; man_rdata = 16'h1234;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0040) begin errors++; $display("FAIL disc_data got v=%0b %h@%h want 1 1234@0040", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_redirect_ack_pop;
        do_reset();
        zw = 1'b1; instr_ready = 1'b0; rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (dut.w_count !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 16'h0006) begin errors++; $display("FAIL rap_setup got cnt=%0d req=%0b addr=%h want 3/1/0006", dut.w_count, imem_req, imem_addr); end
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || dut.w_count !== 3'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL rap_flush got v=%0b cnt=%0d req=%0b want 0/0/0", instr_valid, dut.w_count, imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL rap_newreq got %0b/%h want 1/0100", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr !== 16'h0100) begin errors++; $display("FAIL rap_data got v=%0b %h@%h want 1 0100@0100", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_wrap;
        do_reset();
        zw = 1'b1; instr_ready = 1'b1; rst = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_idle got %0b want 0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_first got %0b/%h want 1/fffe", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0000 || instr_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_second got addr=%h pc=%h want 0000/fffe", imem_addr, instr_pc); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got v=%0b pc=%h want 1/0000", instr_valid, instr_pc); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        zw = 1'b0; instr_ready = 1'b0; rst = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'h0080;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin errors++; $display("FAIL rmid_req got %0b/%h want 1/0080", imem_req, imem_addr); end
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_async got %0b/%h want 0/0000", imem_req, imem_addr); end
        @(negedge clk);
        rst = 1'b0; man_ack = 1'b1; man_rdata = 16'hBEEF;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || dut.w_count !== 3'd0) begin errors++; $display("FAIL rmid_late got v=%0b cnt=%0d want 0/0", instr_valid, dut.w_count); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_restart got %0b/%h want 1/0000", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || dut.w_count !== 3'd0) begin errors++; $display("FAIL rmid_empty got v=%0b cnt=%0d want 0/0", instr_valid, dut.w_count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_discard();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction queue depth in entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the first fetch address after reset.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 redirect_valid  in  1  one-cycle pulse: flush the queue and restart fetch at redirect_pc (branch, jump, jr).
REQ-006 redirect_pc  in  16  new fetch byte address; bit 0 SHALL be ignored and treated as 0.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  16  byte address of the requested halfword; bit 0 is always 0.
REQ-009 imem_ack  in  1  memory response valid; imem_rdata is sampled in the same cycle.
REQ-010 imem_rdata  in  16  instruction word returned by memory.
REQ-011 instr_valid  out  1  queue head is valid.
REQ-012 instr  out  16  queue head instruction; 0 when instr_valid is 0.
REQ-013 instr_pc  out  16  byte address of the queue head; 0 when instr_valid is 0.
REQ-014 instr_ready  in  1  consumer accepts the head; a pop occurs when instr_valid and instr_ready are both 1.

Function
REQ-015 The block SHALL hold a 16-bit fetch_pc, a queue of DEPTH entries {instr, pc}, an occupancy count, and a state machine with states IDLE, WAIT and DISCARD.
REQ-016 imem_req SHALL be 1 exactly in WAIT and DISCARD; imem_addr SHALL equal the address latched at request issue and SHALL hold stable until imem_ack.
REQ-017 IDLE -> WAIT when count < DEPTH and redirect_valid=0; the request address is the current fetch_pc.
REQ-018 WAIT with imem_ack=1 and no redirect: push {imem_rdata, imem_addr} and set fetch_pc to imem_addr+2, wrapping 16'hFFFE -> 16'h0000.
REQ-019 After that push, the state SHALL remain WAIT with the new address if post-push count < DEPTH, giving back-to-back fetch; otherwise it SHALL go to IDLE.
REQ-020 At most one request SHALL be outstanding; no push SHALL occur while the queue is full.
REQ-021 Redirect SHALL take priority over push and pop: count <= 0 and fetch_pc <= {redirect_pc[15:1],1'b0}.
REQ-022 Redirect while in IDLE: stay in IDLE.
REQ-023 Redirect while in WAIT with imem_ack=1: drop the response and go to IDLE.
REQ-024 Redirect while in WAIT with imem_ack=0: go to DISCARD.
REQ-025 DISCARD: keep requesting the old address; on imem_ack drop the data and go to IDLE.
REQ-026 A redirect arriving while in DISCARD SHALL update fetch_pc and leave the state in DISCARD.
REQ-027 A pop coinciding with a redirect SHALL count as delivered to the consumer; the queue is empty the next cycle.
REQ-028 A simultaneous push and pop SHALL leave count unchanged and preserve order; the queue is strictly FIFO.
REQ-029 Latency with a zero-wait memory (ack in the same cycle as req): first imem_req one cycle after rst release; instr_valid the cycle after ack.
REQ-030 Sustained throughput SHALL be one instruction per cycle when memory acks every cycle and the consumer is always ready.

Reset
REQ-031 While rst=1: state=IDLE, fetch_pc=RESET_PC, count=0, queue pointers=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-032 rst asserted mid-transaction SHALL abandon any outstanding request; any imem_ack seen after release without a new request SHALL be ignored.

Structure
REQ-033 The state encoding (IDLE/WAIT/DISCARD), the instruction width constant (16) and the PC increment constant (2) SHALL live in the shared package cpu16_pkg.
REQ-034 The queue SHALL be a sub-module, fetch_fifo, with parameters DEPTH and WIDTH=32; it provides push, pop, flush, count, full and empty.

Verification
REQ-035 Reset then zero-wait memory returning rdata=addr, consumer always ready -> instr_pc sequence 0,2,4,6 on consecutive cycles with instr=instr_pc.
REQ-036 DEPTH=4, consumer not ready -> exactly 4 acks, then imem_req=0 and count=4; one pop -> exactly one new request.
REQ-037 Memory acks after 3 cycles, redirect_pc=16'h0041 during WAIT -> state DISCARD, the old-address data is dropped, next request addr=16'h0040.
REQ-038 Redirect in the same cycle as an ack and a pop with 3 entries queued -> the next cycle instr_valid=0, the acked data is absent, next request at redirect_pc.
REQ-039 redirect_pc=16'hFFFE, zero-wait memory -> fetch addresses 16'hFFFE then 16'h0000.
REQ-040 rst pulsed while in WAIT with ack pending -> after release imem_addr=RESET_PC, the queue is empty, and a late ack does not push.
